// File: rtl/counter_bank_if.sv
// rtl/counter_bank_if.sv - signal bundle between counter_bank and its controller
// Optional sat bus: define COUNTER_BANK_SAT_EN.
interface counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] load_data;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       dir;
    logic                    limit_wr;
    logic [CH_W-1:0]         limit_ch;
    logic [WIDTH-1:0]        limit_data;
`ifdef COUNTER_BANK_SAT_EN
    logic [NUM_CH-1:0]       sat;
`endif
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       tc;
    logic                    any_tc;

    modport master (
`ifdef COUNTER_BANK_SAT_EN
        output sat,
`endif
        output load, load_data, en, dir, limit_wr, limit_ch, limit_data,
        input  out_data, tc, any_tc
    );

    modport slave (
`ifdef COUNTER_BANK_SAT_EN
        input  sat,
`endif
        input  load, load_data, en, dir, limit_wr, limit_ch, limit_data,
        output out_data, tc, any_tc
    );
endinterface

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of loadable up/down counters with terminal-count pulses
// Optional saturating mode: define COUNTER_BANK_SAT_EN.
module counter_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic          clk,
    input  logic          reset,
    counter_bank_if.slave bus
);
    localparam int               CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0]        cnt_q [NUM_CH];
    logic [WIDTH-1:0]        cnt_d [NUM_CH];
    logic [WIDTH-1:0]        lim_q [NUM_CH];
    logic [WIDTH-1:0]        lim_d [NUM_CH];
    logic [NUM_CH-1:0]       tc_q;
    logic [NUM_CH-1:0]       tc_d;
    logic                    any_tc_q;
    logic                    any_tc_d;
    logic [NUM_CH-1:0]       sat_w;
    logic [NUM_CH*WIDTH-1:0] out_w;

`ifdef COUNTER_BANK_SAT_EN
    assign sat_w = bus.sat;
`else
    assign sat_w = '0;
`endif

    // Compares use the registered limit, so a same-cycle limit write only affects later cycles.
    always_comb begin
        tc_d     = '0;
        any_tc_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            lim_d[i] = lim_q[i];
            if (bus.limit_wr && (bus.limit_ch == CH_W'(i))) begin
                lim_d[i] = bus.limit_data;
            end
            if (bus.load[i]) begin
                cnt_d[i] = bus.load_data[i*WIDTH +: WIDTH];
            end else if (bus.en[i]) begin
                if (bus.dir[i]) begin
                    if (cnt_q[i] >= lim_q[i]) begin
                        if (!sat_w[i]) begin
                            cnt_d[i] = '0;
                            tc_d[i]  = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE;
                        tc_d[i]  = sat_w[i] && (cnt_d[i] == lim_q[i]);
                    end
                end else begin
                    if (cnt_q[i] == '0) begin
                        if (!sat_w[i]) begin
                            cnt_d[i] = lim_q[i];
                            tc_d[i]  = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - ONE;
                        tc_d[i]  = sat_w[i] && (cnt_q[i] == ONE);
                    end
                end
            end
        end
        any_tc_d = |tc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                lim_q[i] <= '1;
            end
            tc_q     <= '0;
            any_tc_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                lim_q[i] <= lim_d[i];
            end
            tc_q     <= tc_d;
            any_tc_q <= any_tc_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_w[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    assign bus.out_data = out_w;
    assign bus.tc       = tc_q;
    assign bus.any_tc   = any_tc_q;
endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - self-checking bench for counter_bank
module tb_counter_bank;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int MOD    = 1 << WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();
    counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       lw;
        logic [7:0] ldat;
        logic       e;
        logic       d;
        logic [7:0] ecnt;
        logic       etc;
    } vec_t;
    vec_t tbl [10];

    int m_cnt [NUM_CH];
    int m_lim [NUM_CH];
    logic [NUM_CH-1:0] m_tc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return 32'(bus.out_data[ch*WIDTH +: WIDTH]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.load       = '0;
        bus.load_data  = '0;
        bus.en         = '0;
        bus.dir        = '0;
        bus.limit_wr   = 1'b0;
        bus.limit_ch   = '0;
        bus.limit_data = '0;
`ifdef COUNTER_BANK_SAT_EN
        bus.sat        = '0;
`endif
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0;
            m_lim[i] = MOD - 1;
        end
        m_tc = '0;
    endtask

    // Reference: each enabled channel steps toward its boundary and wraps to the other end.
    task automatic model_step();
        int new_lim [NUM_CH];
        for (int i = 0; i < NUM_CH; i++) begin
            new_lim[i] = m_lim[i];
            if (bus.limit_wr && int'(bus.limit_ch) == i) new_lim[i] = int'(bus.limit_data);
            m_tc[i] = 1'b0;
            if (bus.load[i]) begin
                m_cnt[i] = int'(bus.load_data[i*WIDTH +: WIDTH]);
            end else if (bus.en[i] && bus.dir[i]) begin
                m_tc[i]  = (m_cnt[i] >= m_lim[i]);
                m_cnt[i] = m_tc[i] ? 0 : (m_cnt[i] + 1) % MOD;
            end else if (bus.en[i]) begin
                m_tc[i]  = (m_cnt[i] == 0);
                m_cnt[i] = m_tc[i] ? m_lim[i] : m_cnt[i] - 1;
            end
        end
        m_lim = new_lim;
    endtask

    initial begin
        int pulses;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("reset_cnt%0d", i), cnt_of(i), 0);
        chk("reset_tc", 32'(bus.tc), 0);
        chk("reset_any_tc", 32'(bus.any_tc), 0);

        // Free-running channel 0 through a full wrap.
        do_reset();
        bus.en[0]  = 1'b1;
        bus.dir[0] = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            tick();
            chk($sformatf("run_cnt0_%0d", k), cnt_of(0), 32'(k % 256));
            chk($sformatf("run_tc0_%0d", k), 32'(bus.tc[0]), (k == 256) ? 1 : 0);
            chk($sformatf("run_any_%0d", k), 32'(bus.any_tc), (k == 256) ? 1 : 0);
        end

        // Table: channel 1 with limit 5, up then down.
        tbl[0] = '{1'b1, 8'd5, 1'b0, 1'b1, 8'd0, 1'b0};
        for (int k = 1; k <= 5; k++) tbl[k] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'(k), 1'b0};
        tbl[6] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1};
        tbl[7] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b1};
        tbl[8] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0};
        tbl[9] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b0};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus.limit_wr   = tbl[k].lw;
            bus.limit_ch   = 2'd1;
            bus.limit_data = tbl[k].ldat;
            bus.en[1]      = tbl[k].e;
            bus.dir[1]     = tbl[k].d;
            tick();
            chk($sformatf("tbl_cnt1_%0d", k), cnt_of(1), 32'(tbl[k].ecnt));
            chk($sformatf("tbl_tc1_%0d", k), 32'(bus.tc[1]), 32'(tbl[k].etc));
            chk($sformatf("tbl_any_%0d", k), 32'(bus.any_tc), 32'(tbl[k].etc));
        end

        // Load beats enable; a value above the limit wraps on the next up step.
        do_reset();
        bus.limit_wr = 1'b1; bus.limit_ch = 2'd2; bus.limit_data = 8'd10;
        tick();
        idle();
        bus.load[2] = 1'b1; bus.en[2] = 1'b1; bus.dir[2] = 1'b1;
        bus.load_data[2*WIDTH +: WIDTH] = 8'd200;
        tick();
        chk("ld_cnt2", cnt_of(2), 200);
        chk("ld_tc2", 32'(bus.tc[2]), 0);
        bus.load[2] = 1'b0;
        tick();
        chk("ld_wrap_cnt2", cnt_of(2), 0);
        chk("ld_wrap_tc2", 32'(bus.tc[2]), 1);

        // Limit rewritten in the same cycle as a wrap: old limit governs that wrap.
        do_reset();
        bus.load[3] = 1'b1; bus.load_data[3*WIDTH +: WIDTH] = 8'd7;
        bus.limit_wr = 1'b1; bus.limit_ch = 2'd3; bus.limit_data = 8'd7;
        tick();
        chk("lw_cnt3_load", cnt_of(3), 7);
        bus.load[3] = 1'b0; bus.en[3] = 1'b1; bus.dir[3] = 1'b1; bus.limit_data = 8'd20;
        tick();
        chk("lw_cnt3_wrap", cnt_of(3), 0);
        chk("lw_tc3_wrap", 32'(bus.tc[3]), 1);
        bus.limit_wr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("lw_cnt3_%0d", k), cnt_of(3), 32'(k));
            chk($sformatf("lw_tc3_%0d", k), 32'(bus.tc[3]), 0);
        end
        tick();
        chk("lw_cnt3_rewrap", cnt_of(3), 0);
        chk("lw_tc3_rewrap", 32'(bus.tc[3]), 1);

        // Reset overrides everything in its cycle and restores limits to all-ones.
        do_reset();
        bus.limit_wr = 1'b1; bus.limit_ch = 2'd0; bus.limit_data = 8'd2;
        tick();
        bus.limit_wr = 1'b0;
        bus.en = '1; bus.dir = 4'b0101;
        tick();
        tick();
        bus.load = '1; bus.load_data = 32'h11223344; bus.limit_wr = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("mid_rst_cnt%0d", i), cnt_of(i), 0);
        chk("mid_rst_tc", 32'(bus.tc), 0);
        chk("mid_rst_any", 32'(bus.any_tc), 0);
        idle();
        bus.load = '1; bus.load_data = {4{8'd254}};
        tick();
        bus.load = '0; bus.en = '1; bus.dir = '1;
        tick();
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("mid_rst_255_%0d", i), cnt_of(i), 255);
        chk("mid_rst_tc_255", 32'(bus.tc), 0);
        tick();
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("mid_rst_wrap_%0d", i), cnt_of(i), 0);
        chk("mid_rst_tc_wrap", 32'(bus.tc), 32'hF);
        chk("mid_rst_any_wrap", 32'(bus.any_tc), 1);

`ifdef COUNTER_BANK_SAT_EN
        do_reset();
        bus.limit_wr = 1'b1; bus.limit_ch = 2'd0; bus.limit_data = 8'd3;
        tick();
        idle();
        bus.sat[0] = 1'b1; bus.en[0] = 1'b1; bus.dir[0] = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("sat_cnt0_%0d", k), cnt_of(0), (k < 3) ? 32'(k) : 32'd3);
            chk($sformatf("sat_tc0_%0d", k), 32'(bus.tc[0]), (k == 3) ? 1 : 0);
            pulses += int'(bus.tc[0]);
        end
        chk("sat_pulses", 32'(pulses), 1);
        idle();
`endif

        // Randomised traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.en  = 4'($urandom);
            bus.en  = bus.en | 4'($urandom);
            bus.dir = 4'($urandom);
            bus.load = 4'($urandom) & 4'($urandom) & 4'($urandom);
            for (int i = 0; i < NUM_CH; i++) begin
                bus.load_data[i*WIDTH +: WIDTH] =
                    ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
            end
            bus.limit_wr   = ($urandom_range(0, 5) == 0);
            bus.limit_ch   = 2'($urandom);
            bus.limit_data = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 25));
            model_step();
            tick();
            for (int i = 0; i < NUM_CH; i++)
                chk($sformatf("rnd%0d_cnt%0d", c, i), cnt_of(i), 32'(m_cnt[i]));
            chk($sformatf("rnd%0d_tc", c), 32'(bus.tc), 32'(m_tc));
            chk($sformatf("rnd%0d_any", c), 32'(bus.any_tc), 32'(|m_tc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_bank.md
# counter_bank

Bank of `NUM_CH` independent loadable counters, each `WIDTH` bits wide, with per-channel count enable, up/down direction and a programmable terminal value. Each channel flags every wrap with a one-cycle terminal-count pulse. The bank sits beside the control logic as the shared timer/sequence-count resource, replacing single-channel free-running load counters.

## Interface
- `NUM_CH`, 4: number of channels, 1..16.
- `WIDTH`, 8: counter width in bits, 2..32.
- `CH_W`, `$clog2(NUM_CH)` (minimum 1): width of the channel index. Derived; not overridden.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `load` in `NUM_CH`: per-channel load strobe.
- `load_data` in `NUM_CH*WIDTH`: load values; channel i occupies `[i*WIDTH +: WIDTH]`.
- `en` in `NUM_CH`: per-channel count enable.
- `dir` in `NUM_CH`: 1 = count up, 0 = count down.
- `limit_wr` in 1: write strobe for a terminal-value register.
- `limit_ch` in `CH_W`: channel addressed by `limit_wr`.
- `limit_data` in `WIDTH`: new terminal value.
- `out_data` out `NUM_CH*WIDTH`: current counts, packed as `load_data`.
- `tc` out `NUM_CH`: registered one-cycle terminal-count pulse per channel.
- `any_tc` out 1: registered OR of the next-state `tc` bits. Asserts in the same cycle as `tc`.

## Operation
- Each channel holds a count register `cnt[i]` and a limit register `lim[i]`.
- Per-channel update priority, evaluated each cycle: `reset` > `load[i]` > `en[i]` > hold.
- Load: `cnt[i] <= load_data[i]`, with no range check. `tc[i]` stays 0.
- Count up with `en[i]=1`, `dir[i]=1`:
  - If `cnt >= lim`: `cnt <= 0` and `tc[i]` pulses.
  - Otherwise `cnt <= cnt + 1`.
  - The `>=` compare lets a loaded value above `lim` wrap on its next enabled cycle.
- Count down with `en[i]=1`, `dir[i]=0`:
  - If `cnt == 0`: `cnt <= lim` and `tc[i]` pulses.
  - Otherwise `cnt <= cnt - 1`.
- Arithmetic is modulo 2^`WIDTH` and unsigned. With `lim` all-ones, up mode is a plain free-running counter.
- Limit write: `lim[limit_ch] <= limit_data`.
  - An out-of-range `limit_ch` (≥ `NUM_CH`) is ignored.
  - The compare in a given cycle always uses the old `lim`. A new value takes effect on the next cycle.
- A `dir` change mid-count takes effect on the same cycle. There is no pipeline.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- `tc[i]` is 0 in every cycle where no wrap occurred, including load, hold and reset cycles.

## Timing
- Latency: `out_data` reflects any load/count/limit action one clock after the inputs are sampled.
- `tc`/`any_tc` are registered and asserted in the same cycle `out_data` shows the wrapped value.
- Reset values, one cycle after `reset` is sampled high:
  - `cnt` = 0, `lim` = all-ones.
  - `tc` = 0, `any_tc` = 0.
- Reset asserted mid-count overrides `load`, `en` and `limit_wr` in that cycle.
- No combinational path from any input to any output.

## Configuration
- Macro: `COUNTER_BANK_SAT_EN`.
- Defined:
  - Adds input port `sat` (`NUM_CH` bits).
  - With `sat[i]=1`, channel i saturates instead of wrapping:
    - Up at `cnt >= lim`: `cnt` holds unchanged.
    - Down at `cnt == 0`: `cnt` holds at 0.
  - `tc[i]` pulses once, on the cycle the count first reaches the boundary value (`lim` up, 0 down). It stays low while held.
  - `load` still overrides.
- Undefined: the `sat` port is absent and all channels always wrap as described.

## Test plan
All scenarios use NUM_CH=4, WIDTH=8.
- Reset then run: `en[0]=1`, `dir[0]=1` for 258 cycles.
  - `cnt0` sequence 0..255, 0, 1.
  - `tc[0]` and `any_tc` high only on the cycle showing 0 after 255.
- Limit and wrap: write `lim[1]=5`, then count up channel 1.
  - Sequence 0..5, 0 with `tc[1]` pulse.
  - Then `dir[1]=0`: sequence 0→5 with `tc[1]` pulse, then 4, 3.
- Load precedence and above-limit load: with `lim[2]=10`, assert `load[2]=1`, `en[2]=1`, `load_data=200`.
  - `cnt2`=200 and no `tc` on that cycle.
  - Next enabled up cycle gives 0 with a `tc[2]` pulse.
- Limit write during wrap: `cnt3=7`, `lim[3]=7`, `en`=1 up, with the same-cycle `limit_wr` setting `lim[3]=20`.
  - `cnt3` → 0 with `tc[3]` pulse (old limit used).
  - It then counts to 20 before the next wrap.
- Reset mid-operation: all channels counting with `load` asserted and `reset=1` for one cycle.
  - All counts 0, `tc`=0, all `lim`=255 on the next cycle.
- With `COUNTER_BANK_SAT_EN`: `sat[0]=1`, `lim[0]=3`, count up from 0.
  - Sequence 0, 1, 2, 3, 3, 3.
  - Single `tc[0]` pulse on the first 3.
